// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: walks a {dev,reg,dat} init table and issues one 3-byte I2C write per entry with timeout/retry.
// Optional macro CFG_SEQ_DELAY_CMD_EN turns dev==8'hFF entries into {reg,dat}*1024-cycle delays.
module i2c_cfg_seq #(
  parameter int ENTRIES    = 16,
  parameter int IDX_W      = 8,
  parameter int PWR_WAIT   = 1_000_000,
  parameter int GAP_CYCLES = 250,
  parameter int TIMEOUT    = 100_000,
  parameter int MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [23:0]      lut_data,
  output logic             m_wr_req,
  output logic [7:0]       m_wr_data,
  output logic [1:0]       m_wr_addr_lenth,
  input  logic             m_byte_next,
  input  logic             m_wr_done,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_index
);
  typedef enum logic [3:0] {IDLE, PWR, FETCH, LATCH, SEND_DEV, SEND_REG, SEND_DAT, GAP, DONE, ERROR, DELAY} state_t;
  localparam logic [31:0] PW = 32'(PWR_WAIT);
  localparam logic [31:0] GW = 32'(GAP_CYCLES);
  localparam logic [31:0] TW = 32'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
  logic [15:0] entry_q, entry_d;
  logic [7:0] data_q, data_d, retry_q, retry_d;
  logic req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic tmo, fault;
  assign cnt_inc = cnt_q + 32'd1;
  assign tmo = req_q && cnt_q >= TW;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_inc;
    idx_d = idx_q;
    entry_d = entry_q;
    data_d = data_q;
    req_d = req_q;
    retry_d = retry_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    err_idx_d = err_idx_q;
    fault = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = PWR;
        cnt_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
        idx_d = '0;
        retry_d = '0;
      end
      PWR: state_d = cnt_inc >= PW ? FETCH : PWR;
      FETCH: state_d = LATCH;
      LATCH: begin
        entry_d = lut_data[15:0];
        cnt_d = '0;
`ifdef CFG_SEQ_DELAY_CMD_EN
        if (lut_data[23:16] == 8'hFF) state_d = DELAY;
        else
`endif
        begin
          data_d = lut_data[23:16];
          req_d = 1'b1;
          state_d = SEND_DEV;
        end
      end
      SEND_DEV: if (m_wr_done || tmo) fault = 1'b1;
        else if (m_byte_next) begin
          data_d = entry_q[15:8];
          state_d = SEND_REG;
        end
      SEND_REG: if (m_wr_done || tmo) fault = 1'b1;
        else if (m_byte_next) begin
          data_d = entry_q[7:0];
          state_d = SEND_DAT;
        end
      SEND_DAT: if (m_wr_done) begin
          req_d = 1'b0;
          retry_d = '0;
          cnt_d = '0;
          state_d = GAP;
        end else if (tmo) fault = 1'b1;
      // a nonzero retry count here means the last attempt failed and the same index is refetched
      GAP: if (cnt_inc >= GW) begin
        cnt_d = '0;
        if (retry_q != '0) state_d = FETCH;
        else if (idx_q == LAST) begin
          state_d = DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
`ifdef CFG_SEQ_DELAY_CMD_EN
      DELAY: if (cnt_inc >= {6'd0, entry_q, 10'd0}) begin
        cnt_d = '0;
        retry_d = '0;
        state_d = GAP;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (fault) begin
      req_d = 1'b0;
      cnt_d = '0;
      if (retry_q < 8'(MAX_RETRY)) begin
        retry_d = retry_q + 8'd1;
        state_d = GAP;
      end else begin
        state_d = ERROR;
        err_d = 1'b1;
        err_idx_d = idx_q;
        busy_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      entry_q <= '0;
      data_q <= '0;
      req_q <= 1'b0;
      retry_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      entry_q <= entry_d;
      data_q <= data_d;
      req_q <= req_d;
      retry_q <= retry_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      err_idx_q <= err_idx_d;
    end
  end
  assign lut_index = idx_q;
  assign m_wr_req = req_q;
  assign m_wr_data = data_q;
  assign m_wr_addr_lenth = 2'd1;
  assign busy = busy_q;
  assign cfg_done = done_q;
  assign cfg_err = err_q;
  assign err_index = err_idx_q;
endmodule
